// File: rtl/nearest_coord_gen_pkg.sv
// Shared video-scaler definitions for the nearest-neighbour coordinate path:
// fixed-point format, coordinate width and the line-sequencer state encoding.
package nearest_coord_gen_pkg;

  localparam int SCL_FRAC = 16;
  localparam int SCL_CW   = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LREQ   = 2'd1,
    LINE   = 2'd2,
    HBLANK = 2'd3
  } scl_state_e;

endpackage

// File: rtl/nearest_coord_gen_step_acc.sv
// Fixed-point step accumulator with clear/advance; the integer part is
// clamped to MAXV and presented as a registered coordinate.
module nearest_step_acc
  import nearest_coord_gen_pkg::*;
#(
  parameter int          FRAC = SCL_FRAC,
  parameter int unsigned STEP = 0,
  parameter int unsigned MAXV = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  output logic [SCL_CW-1:0] coord
);

  localparam int ACC_W = FRAC + SCL_CW;
  localparam logic [ACC_W-1:0]  STEP_V = ACC_W'(STEP);
  localparam logic [SCL_CW-1:0] MAX_V  = SCL_CW'(MAXV);

  logic [ACC_W-1:0]  acc, acc_d;
  logic [SCL_CW-1:0] int_d;

  always_comb begin
    acc_d = acc;
    if (clr)      acc_d = '0;
    else if (adv) acc_d = acc + STEP_V;
    int_d = acc_d[FRAC +: SCL_CW];
    if (int_d > MAX_V) int_d = MAX_V;
  end

  // coord tracks clamp(acc) one-for-one so it is valid the cycle acc is
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      coord <= '0;
    end else begin
      acc   <= acc_d;
      coord <= int_d;
    end
  end

endmodule

// File: rtl/nearest_coord_gen.sv
// Nearest-neighbour scaler coordinate generator: walks the output raster and
// emits the source (x,y) per output pixel, requesting source lines as needed.
module nearest_coord_gen
  import nearest_coord_gen_pkg::*;
#(
  parameter int SRC_W   = 640,
  parameter int SRC_H   = 480,
  parameter int DST_W   = 1280,
  parameter int DST_H   = 720,
  parameter int H_BLANK = 16,
  parameter int FRAC    = SCL_FRAC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [SCL_CW-1:0] src_x,
  output logic [SCL_CW-1:0] src_y,
  output logic              dst_sol,
  output logic              dst_sof,
  output logic              dst_eol,
  output logic              line_req,
  output logic [SCL_CW-1:0] line_req_y,
  output logic              busy
);

  localparam longint unsigned X_STEP = (longint'(SRC_W) << FRAC) / longint'(DST_W);
  localparam longint unsigned Y_STEP = (longint'(SRC_H) << FRAC) / longint'(DST_H);

  localparam int COL_W = (DST_W > 1) ? $clog2(DST_W) : 1;
  localparam int ROW_W = (DST_H > 1) ? $clog2(DST_H) : 1;
  localparam int HB_W  = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(DST_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DST_H - 1);
  localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(H_BLANK - 1);

  scl_state_e        state, state_n;
  logic [COL_W-1:0]  col, col_n;
  logic [ROW_W-1:0]  row, row_n;
  logic [HB_W-1:0]   hb_cnt, hb_n;
  logic [SCL_CW-1:0] prev_y;
  logic              xfer, lreq_n;
  logic              x_clr, x_adv, y_clr, y_adv;

  assign xfer = out_valid & out_ready;

  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    hb_n    = hb_cnt;
    lreq_n  = 1'b0;
    x_clr   = 1'b0;
    x_adv   = 1'b0;
    y_clr   = 1'b0;
    y_adv   = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = LREQ;
        lreq_n  = 1'b1;
      end
      LREQ: state_n = LINE;
      LINE: if (xfer) begin
        if (col == COL_LAST) begin
          col_n = '0;
          x_clr = 1'b1;
          if (row == ROW_LAST) begin
            state_n = IDLE;
            row_n   = '0;
            y_clr   = 1'b1;
          end else begin
            state_n = HBLANK;
            row_n   = row + 1'b1;
            y_adv   = 1'b1;
            hb_n    = '0;
          end
        end else begin
          col_n = col + 1'b1;
          x_adv = 1'b1;
        end
      end
      HBLANK: if (hb_cnt == HB_LAST) begin
        state_n = LREQ;
        // src_y already holds the next row here; skip the fetch on a repeat
        lreq_n  = (src_y != prev_y);
      end else begin
        hb_n = hb_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  nearest_step_acc #(.FRAC(FRAC), .STEP(32'(X_STEP)), .MAXV(SRC_W - 1)) u_x_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (x_clr),
    .adv   (x_adv),
    .coord (src_x)
  );

  nearest_step_acc #(.FRAC(FRAC), .STEP(32'(Y_STEP)), .MAXV(SRC_H - 1)) u_y_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (y_clr),
    .adv   (y_adv),
    .coord (src_y)
  );

  // Flags are registered from next-state values so they line up with the
  // registered coordinates and never see out_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      hb_cnt     <= '0;
      prev_y     <= '0;
      out_valid  <= 1'b0;
      dst_sol    <= 1'b0;
      dst_sof    <= 1'b0;
      dst_eol    <= 1'b0;
      line_req   <= 1'b0;
      line_req_y <= '0;
      busy       <= 1'b0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      row       <= row_n;
      hb_cnt    <= hb_n;
      out_valid <= (state_n == LINE);
      dst_sol   <= (state_n == LINE) && (col_n == '0);
      dst_sof   <= (state_n == LINE) && (col_n == '0) && (row_n == '0);
      dst_eol   <= (state_n == LINE) && (col_n == COL_LAST);
      busy      <= (state_n != IDLE);
      line_req  <= lreq_n;
      if (state_n == LREQ) prev_y <= src_y;
      if (lreq_n) line_req_y <= src_y;
    end
  end

endmodule

// File: tb/tb_nearest_coord_gen.sv
// Directed bench for nearest_coord_gen: default upscale lines, backpressure,
// ignored starts, mid-line reset, plus a small full frame and a downscale frame.
module tb_nearest_coord_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  localparam int XS   = (640 * 65536) / 1280;
  localparam int YS   = (480 * 65536) / 720;
  localparam int XS_S = (8 * 65536) / 16;
  localparam int YS_S = (6 * 65536) / 12;

  logic start = 1'b0, out_ready = 1'b0;
  logic out_valid, dst_sol, dst_sof, dst_eol, line_req, busy;
  logic [10:0] src_x, src_y, line_req_y;

  logic start_s = 1'b0, ready_s = 1'b1;
  logic out_valid_s, dst_sol_s, dst_sof_s, dst_eol_s, line_req_s, busy_s;
  logic [10:0] src_x_s, src_y_s, line_req_y_s;

  logic start_d = 1'b0, ready_d = 1'b1;
  logic out_valid_d, dst_sol_d, dst_sof_d, dst_eol_d, line_req_d, busy_d;
  logic [10:0] src_x_d, src_y_d, line_req_y_d;

  nearest_coord_gen dut (
    .clk(clk), .rst(rst), .start(start), .out_ready(out_ready),
    .out_valid(out_valid), .src_x(src_x), .src_y(src_y),
    .dst_sol(dst_sol), .dst_sof(dst_sof), .dst_eol(dst_eol),
    .line_req(line_req), .line_req_y(line_req_y), .busy(busy)
  );

  nearest_coord_gen #(.SRC_W(8), .SRC_H(6), .DST_W(16), .DST_H(12), .H_BLANK(4)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .out_ready(ready_s),
    .out_valid(out_valid_s), .src_x(src_x_s), .src_y(src_y_s),
    .dst_sol(dst_sol_s), .dst_sof(dst_sof_s), .dst_eol(dst_eol_s),
    .line_req(line_req_s), .line_req_y(line_req_y_s), .busy(busy_s)
  );

  nearest_coord_gen #(.SRC_W(100), .SRC_H(100), .DST_W(33), .DST_H(33), .H_BLANK(2)) dut_d (
    .clk(clk), .rst(rst), .start(start_d), .out_ready(ready_d),
    .out_valid(out_valid_d), .src_x(src_x_d), .src_y(src_y_d),
    .dst_sol(dst_sol_d), .dst_sof(dst_sof_d), .dst_eol(dst_eol_d),
    .line_req(line_req_d), .line_req_y(line_req_y_d), .busy(busy_d)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  function automatic int ex(input int c);
    return (c * XS) >>> 16;
  endfunction

  function automatic int ey(input int r);
    return (r * YS) >>> 16;
  endfunction

  // Pulse start, check the LREQ cycle, end on the first LINE negedge.
  task automatic start_frame(input string tag);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, "_lreq_valid"}, out_valid, 0);
    chk({tag, "_lreq_busy"}, busy, 1);
    chk({tag, "_lreq_pulse"}, line_req, 1);
    chk({tag, "_lreq_y"}, line_req_y, 0);
    @(negedge clk);
    chk({tag, "_first_valid"}, out_valid, 1);
  endtask

  // mode 0: ready=1; mode 1: ready pattern 1,0,0,1; mode 2: ready=1 with stray starts.
  task automatic run_line(input int row, input int mode, input int abort_col);
    int col = 0, k = 0, bad = 0;
    logic r;
    while (col < 1280 && k < 6000 && !(abort_col >= 0 && col == abort_col)) begin
      r = (mode == 1) ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      if (out_valid !== 1'b1 || src_x !== 11'(ex(col)) || src_y !== 11'(ey(row)) ||
          dst_sol !== (col == 0) || dst_eol !== (col == 1279) ||
          dst_sof !== (col == 0 && row == 0))
        bad++;
      if (mode == 2) start = (k % 97 == 5);
      out_ready = r;
      @(negedge clk);
      if (r) col++;
      k++;
    end
    start = 1'b0;
    chk($sformatf("row%0d_pixels", row), bad, 0);
    if (abort_col < 0) chk($sformatf("row%0d_len", row), col, 1280);
    else               chk($sformatf("row%0d_abort_col", row), col, abort_col);
  endtask

  // Blank gap is H_BLANK idle cycles plus the one LREQ cycle.
  task automatic measure_gap(input int next_row, input bit poke_start);
    int gap = 0, lr = 0, busy_low = 0;
    logic [10:0] ly = '0;
    bit want_req;
    while (out_valid !== 1'b1 && gap < 200) begin
      if (poke_start) start = (gap == 3 || gap == 10);
      if (line_req === 1'b1) begin lr++; ly = line_req_y; end
      if (busy !== 1'b1) busy_low++;
      @(negedge clk);
      gap++;
    end
    start = 1'b0;
    want_req = (ey(next_row) != ey(next_row - 1));
    chk($sformatf("gap%0d_len", next_row), gap, 17);
    chk($sformatf("gap%0d_busy", next_row), busy_low, 0);
    chk($sformatf("gap%0d_line_req", next_row), lr, want_req ? 1 : 0);
    if (want_req) chk($sformatf("gap%0d_line_req_y", next_row), ly, ey(next_row));
  endtask

  initial begin
    int cnt_v, cnt_b;
    int cs, rs, bad_s, lreq_s, lreq_bad_s, pix_s;
    int cd, rd, maxx, maxy, bad_last, bad_len, last_y;
    bit done_s, done_d;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_line_req", line_req, 0);
    chk("rst_src_x", src_x, 0);
    chk("rst_src_y", src_y, 0);
    chk("rst_flags", {dst_sol, dst_sof, dst_eol}, 0);
    chk("rst_busy_small", busy_s, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    cnt_v = 0;
    repeat (5) begin @(negedge clk); if (out_valid !== 1'b0) cnt_v++; end
    chk("idle_no_output", cnt_v, 0);

    // default frame: plain line, backpressured line, stray starts, then reset mid-line
    start_frame("f0");
    run_line(0, 0, -1);
    measure_gap(1, 1'b1);
    run_line(1, 1, -1);
    measure_gap(2, 1'b0);
    run_line(2, 2, -1);
    measure_gap(3, 1'b0);
    run_line(3, 0, 500);
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_src_x", src_x, 0);
    chk("arst_src_y", src_y, 0);
    chk("arst_flags", {dst_sol, dst_sof, dst_eol, line_req}, 0);
    chk("arst_line_req_y", line_req_y, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt_v = 0; cnt_b = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid !== 1'b0) cnt_v++;
      if (busy !== 1'b0) cnt_b++;
    end
    chk("post_rst_silent", cnt_v, 0);
    chk("post_rst_not_busy", cnt_b, 0);
    start_frame("f1");
    run_line(0, 0, -1);
    out_ready = 1'b0;

    // small 2x frame and 100->33 downscale frame, run side by side
    cs = 0; rs = 0; bad_s = 0; lreq_s = 0; lreq_bad_s = 0; pix_s = 0;
    cd = 0; rd = 0; maxx = 0; maxy = 0; bad_last = 0; bad_len = 0; last_y = -1;
    done_s = 0; done_d = 0;
    @(negedge clk); start_s = 1'b1; start_d = 1'b1;
    @(negedge clk); start_s = 1'b0; start_d = 1'b0;
    for (int k = 0; k < 3000 && !(done_s && done_d); k++) begin
      if (!done_s) begin
        if (line_req_s === 1'b1) begin
          lreq_s++;
          if (rs % 2 != 0 || line_req_y_s !== 11'(rs / 2)) lreq_bad_s++;
        end
        if (out_valid_s === 1'b1) begin
          pix_s++;
          if (src_x_s !== 11'((cs * XS_S) >>> 16) || src_y_s !== 11'((rs * YS_S) >>> 16) ||
              dst_eol_s !== (cs == 15) || dst_sof_s !== (cs == 0 && rs == 0))
            bad_s++;
          if (cs == 15) begin cs = 0; rs++; end else cs++;
        end else if (rs == 12) begin
          chk("s_busy_fall", busy_s, 0);
          done_s = 1;
        end
      end
      if (!done_d) begin
        if (out_valid_d === 1'b1) begin
          if (int'(src_x_d) > maxx) maxx = int'(src_x_d);
          if (int'(src_y_d) > maxy) maxy = int'(src_y_d);
          cd++;
          if (dst_eol_d === 1'b1) begin
            if (src_x_d !== 11'd96) bad_last++;
            if (cd != 33) bad_len++;
            last_y = int'(src_y_d);
            cd = 0;
            rd++;
          end
        end else if (rd == 33) begin
          done_d = 1;
        end
      end
      @(negedge clk);
    end
    chk("s_done", done_s, 1);
    chk("s_pixels", pix_s, 192);
    chk("s_rows", rs, 12);
    chk("s_coords", bad_s, 0);
    chk("s_line_req_count", lreq_s, 6);
    chk("s_line_req_rows", lreq_bad_s, 0);
    chk("d_done", done_d, 1);
    chk("d_rows", rd, 33);
    chk("d_max_x_le_99", maxx <= 99, 1);
    chk("d_max_y_le_99", maxy <= 99, 1);
    chk("d_last_x_96", bad_last, 0);
    chk("d_line_len", bad_len, 0);
    chk("d_last_y", last_y, 96);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
